// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// latency counter width and the legal-latency check.
package mem_resp_pkg;

  localparam int LAT_BITS = 4;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_RD,
    BUSY_WR,
    RESPOND,
    RELEASE
  } state_t;

  // Latency must fit the down-counter and be at least one cycle.
  function automatic bit lat_in_range(input int lat);
    return (lat >= 1) && (lat <= (1 << LAT_BITS) - 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Valid/ready read and write request bus between the GPU requester (master)
// and the memory responder (slave).
interface mem_responder_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);

  logic                 read_valid;
  logic [ADDR_BITS-1:0] read_address;
  logic                 read_ready;
  logic [DATA_BITS-1:0] read_data;
  logic                 write_valid;
  logic [ADDR_BITS-1:0] write_address;
  logic [DATA_BITS-1:0] write_data;
  logic                 write_ready;

  modport master (
    output read_valid, read_address, write_valid, write_address, write_data,
    input  read_ready, read_data, write_ready
  );

  modport slave (
    input  read_valid, read_address, write_valid, write_address, write_data,
    output read_ready, read_data, write_ready
  );

endinterface

// File: rtl/mem_resp_array.sv
// Single-port storage array: one combinational read port, one synchronous
// write port shared between host preload and committed writes (load wins).
module mem_resp_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_address,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_address,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Write mux: host preload takes priority over a committing write.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_address] <= load_data;
    end else if (wr_en) begin
      mem[wr_address] <= wr_data;
    end
  end

  assign rd_data = mem[rd_address];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the GPU valid/ready memory interface.
// Optional feature macro: MEM_RESP_PERF_EN adds saturating completed-read
// and completed-write counters (rd_count, wr_count).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1,
  parameter int WRITE_EN      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data
`ifdef MEM_RESP_PERF_EN
  ,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
`endif
);

  if (!lat_in_range(READ_LATENCY)) begin : g_bad_read_latency
    $error("mem_responder: READ_LATENCY %0d outside 1..15", READ_LATENCY);
  end
  if (!lat_in_range(WRITE_LATENCY)) begin : g_bad_write_latency
    $error("mem_responder: WRITE_LATENCY %0d outside 1..15", WRITE_LATENCY);
  end

  localparam logic [LAT_BITS-1:0] RD_LOAD = LAT_BITS'(READ_LATENCY - 1);
  localparam logic [LAT_BITS-1:0] WR_LOAD = LAT_BITS'(WRITE_LATENCY - 1);
  localparam logic [LAT_BITS-1:0] ONE     = LAT_BITS'(1);

  state_t                state;
  logic [LAT_BITS-1:0]   count;
  logic [ADDR_BITS-1:0]  acc_addr;
  logic [DATA_BITS-1:0]  acc_data;
  logic                  acc_write;
  logic                  read_ready_q;
  logic                  write_ready_q;
  logic [DATA_BITS-1:0]  read_data_q;
  logic [DATA_BITS-1:0]  rd_word;
  logic                  rd_fire;
  logic                  wr_fire;

  // A write commits only when no preload owns the array port this edge;
  // otherwise RESPOND simply repeats. Reset suppresses any commit.
  assign rd_fire = (state == RESPOND) && !acc_write;
  assign wr_fire = (state == RESPOND) && acc_write && !load_en && reset
                   && (WRITE_EN != 0);

  mem_resp_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_array (
    .clk          (clk),
    .load_en      (load_en),
    .load_address (load_address),
    .load_data    (load_data),
    .wr_en        (wr_fire),
    .wr_address   (acc_addr),
    .wr_data      (acc_data),
    .rd_address   (acc_addr),
    .rd_data      (rd_word)
  );

  // Request FSM with registered ready pulses and read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= '0;
      acc_addr      <= '0;
      acc_data      <= '0;
      acc_write     <= 1'b0;
      read_ready_q  <= 1'b0;
      write_ready_q <= 1'b0;
      read_data_q   <= '0;
    end else begin
      read_ready_q  <= 1'b0;
      write_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.read_valid) begin
            acc_addr  <= bus.read_address;
            acc_write <= 1'b0;
            count     <= RD_LOAD;
            state     <= (READ_LATENCY == 1) ? RESPOND : BUSY_RD;
          end else if (bus.write_valid && (WRITE_EN != 0)) begin
            acc_addr  <= bus.write_address;
            acc_data  <= bus.write_data;
            acc_write <= 1'b1;
            count     <= WR_LOAD;
            state     <= (WRITE_LATENCY == 1) ? RESPOND : BUSY_WR;
          end
        end
        BUSY_RD, BUSY_WR: begin
          count <= count - ONE;
          if (count == ONE) begin
            state <= RESPOND;
          end
        end
        RESPOND: begin
          if (rd_fire) begin
            read_data_q  <= rd_word;
            read_ready_q <= 1'b1;
            state        <= RELEASE;
          end else if (wr_fire) begin
            write_ready_q <= 1'b1;
            state         <= RELEASE;
          end
        end
        RELEASE: begin
          if (acc_write ? !bus.write_valid : !bus.read_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.read_ready  = read_ready_q;
  assign bus.read_data   = read_data_q;
  assign bus.write_ready = write_ready_q;

`ifdef MEM_RESP_PERF_EN
  // Saturating counts of issued read and write ready pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_fire && (rd_count != '1)) rd_count <= rd_count + 16'd1;
      if (wr_fire && (wr_count != '1)) wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule
